sqrt_result_checker: RTL

- Sequential checker that receives a root R and its radicand X from the square-root pipeline's output side.
- Squares R with an iterative shift-add multiplier and confirms R^2 <= X < (R+1)^2.
- Sits downstream of the square-root unit and is used for self-check in benches and in-system BIST.
- Uses a start/busy/done handshake with its own FSM.

---
 rtl/sqrt_result_checker.sv | 111 +++++++++++
 1 files changed

// File: rtl/sqrt_result_checker.sv
// Square-root result checker: squares root R with a shift-add multiplier and
// confirms R^2 <= X < (R+1)^2 under a start/busy/done handshake.
module sqrt_result_checker #(
  parameter int unsigned W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [W-1:0]     root_i,
  input  logic [2*W-1:0]   radicand_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [2*W-1:0]   square_o,
  output logic             pass_o
);

  localparam int unsigned CntW = $clog2(W) + 1;

  typedef enum logic [1:0] {StIdle, StMul, StCheck, StDone} state_e;

  state_e              state_q, state_d;
  logic [W-1:0]        mcand_q, mcand_d;
  logic [W-1:0]        mplier_q, mplier_d;
  logic [2*W-1:0]      radicand_q, radicand_d;
  logic [2*W-1:0]      acc_q, acc_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2*W-1:0]      square_q, square_d;
  logic                pass_q, pass_d;

  logic [2*W-1:0]      mcand_ext;
  logic [2*W-1:0]      addend;
  logic [2*W:0]        nxt;

  assign mcand_ext = {{W{1'b0}}, mcand_q};
  assign addend    = mcand_ext << cnt_q;
  // (R+1)^2 = R^2 + 2R + 1; the extra bit keeps 2^(2W) from wrapping to zero.
  assign nxt       = {1'b0, acc_q} + ({1'b0, mcand_ext} << 1) + (2*W+1)'(1);

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    radicand_d = radicand_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    square_d   = square_q;
    pass_d     = pass_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mcand_d    = root_i;
          mplier_d   = root_i;
          radicand_d = radicand_i;
          acc_d      = '0;
          cnt_d      = '0;
          state_d    = StMul;
        end
      end
      StMul: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + addend;
        end
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(W - 1)) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        square_d = acc_q;
        pass_d   = (acc_q <= radicand_q) && ({1'b0, radicand_q} < nxt);
        state_d  = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mcand_q    <= '0;
      mplier_q   <= '0;
      radicand_q <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      square_q   <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      radicand_q <= radicand_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      square_q   <= square_d;
      pass_q     <= pass_d;
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign done_o   = (state_q == StDone);
  assign square_o = square_q;
  assign pass_o   = pass_q;

endmodule
